// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the write-back arbiter and the MEM/WB stage, the MDU,
// the register-file write port and the hazard unit.
interface wb_port_arbiter_if;
    logic [4:0]  WB_Rd;
    logic [31:0] WB_Result;
    logic        WB_RegWrite;
    logic        MDU_Valid;
    logic [4:0]  MDU_Rd;
    logic [31:0] MDU_Data;
    logic        MDU_Ready;
    logic        RF_WriteEn;
    logic [4:0]  RF_WriteAddr;
    logic [31:0] RF_WriteData;
    logic        Stall_Req;
    logic        Pend_Valid;
    logic [4:0]  Pend_Rd;

    modport slave (
        input  WB_Rd, WB_Result, WB_RegWrite, MDU_Valid, MDU_Rd, MDU_Data,
        output MDU_Ready, RF_WriteEn, RF_WriteAddr, RF_WriteData, Stall_Req, Pend_Valid, Pend_Rd
    );

    modport master (
        output WB_Rd, WB_Result, WB_RegWrite, MDU_Valid, MDU_Rd, MDU_Data,
        input  MDU_Ready, RF_WriteEn, RF_WriteAddr, RF_WriteData, Stall_Req, Pend_Valid, Pend_Rd
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline write-back (fixed priority) and
// a one-entry MDU result buffer, with a starvation counter that requests a bubble.
module wb_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    wb_port_arbiter_if.slave  bus
);

    localparam logic [4:0] Limit = 5'(STARVE_LIMIT);

    logic        buf_valid_q, buf_valid_d;
    logic [4:0]  buf_rd_q, buf_rd_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        stall_q, stall_d;

    logic       wb_live, grant_buf, supersede, mdu_ready, capture;
    logic [4:0] cnt_inc;

    assign wb_live   = bus.WB_RegWrite && (bus.WB_Rd != 5'd0);
    assign grant_buf = buf_valid_q && !wb_live;
    assign supersede = buf_valid_q && wb_live && (bus.WB_Rd == buf_rd_q);
    assign mdu_ready = !buf_valid_q && !reset;
    // Results aimed at r0 are accepted but never stored.
    assign capture   = bus.MDU_Valid && mdu_ready && (bus.MDU_Rd != 5'd0);
    assign cnt_inc   = {1'b0, starve_cnt_q} + 5'd1;

    always_comb begin
        buf_valid_d  = buf_valid_q;
        buf_rd_d     = buf_rd_q;
        buf_data_d   = buf_data_q;
        starve_cnt_d = starve_cnt_q;
        stall_d      = stall_q;
        if (buf_valid_q) begin
            if (grant_buf || supersede) begin
                buf_valid_d  = 1'b0;
                starve_cnt_d = 4'd0;
                stall_d      = 1'b0;
            end else begin
                // Denied: the pipeline took the port this cycle.
                if ({1'b0, starve_cnt_q} < Limit) starve_cnt_d = cnt_inc[3:0];
                if (cnt_inc >= Limit) stall_d = 1'b1;
            end
        end else begin
            starve_cnt_d = 4'd0;
            stall_d      = 1'b0;
            if (capture) begin
                buf_valid_d = 1'b1;
                buf_rd_d    = bus.MDU_Rd;
                buf_data_d  = bus.MDU_Data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q  <= 1'b0;
            buf_rd_q     <= 5'd0;
            buf_data_q   <= 32'd0;
            starve_cnt_q <= 4'd0;
            stall_q      <= 1'b0;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_rd_q     <= buf_rd_d;
            buf_data_q   <= buf_data_d;
            starve_cnt_q <= starve_cnt_d;
            stall_q      <= stall_d;
        end
    end

    always_comb begin
        bus.RF_WriteEn   = 1'b0;
        bus.RF_WriteAddr = 5'd0;
        bus.RF_WriteData = 32'd0;
        // Write port is held idle while reset is asserted.
        if (!reset) begin
            if (wb_live) begin
                bus.RF_WriteEn   = 1'b1;
                bus.RF_WriteAddr = bus.WB_Rd;
                bus.RF_WriteData = bus.WB_Result;
            end else if (buf_valid_q) begin
                bus.RF_WriteEn   = 1'b1;
                bus.RF_WriteAddr = buf_rd_q;
                bus.RF_WriteData = buf_data_q;
            end
        end
    end

    assign bus.MDU_Ready  = mdu_ready;
    assign bus.Stall_Req  = stall_q;
    assign bus.Pend_Valid = buf_valid_q;
    assign bus.Pend_Rd    = buf_valid_q ? buf_rd_q : 5'd0;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: inputs change 1 time unit after the rising edge,
// outputs are checked mid-cycle.
module tb_wb_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;

    wb_port_arbiter_if bus ();

    wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_wb(input logic we, input logic [4:0] rd, input logic [31:0] d);
        bus.WB_RegWrite = we;
        bus.WB_Rd       = rd;
        bus.WB_Result   = d;
    endtask

    task automatic drive_mdu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        bus.MDU_Valid = v;
        bus.MDU_Rd    = rd;
        bus.MDU_Data  = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_wb(1'b1, 5'd5, 32'h55);
        drive_mdu(1'b1, 5'd9, 32'h99);
        tick(); tick();
        settle();
        tests_run++;
        if ({bus.MDU_Ready, bus.Pend_Valid, bus.Pend_Rd, bus.Stall_Req} !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_status: got %b, expected 0", {bus.MDU_Ready, bus.Pend_Valid,
                     bus.Pend_Rd, bus.Stall_Req});
        end
        tests_run++;
        if ({bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData} !== 38'd0) begin
            tests_failed++;
            $display("FAIL reset_port_idle: got %h, expected 0",
                     {bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData});
        end
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        drive_mdu(1'b0, 5'd0, 32'd0);
        reset = 1'b0;
        settle();
        tests_run++;
        if (bus.MDU_Ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL ready_after_reset: got %b, expected 1", bus.MDU_Ready);
        end
    endtask

    task automatic test_passthrough();
        tick();
        drive_wb(1'b1, 5'd5, 32'h1234);
        settle();
        tests_run++;
        if ({bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData} !== {1'b1, 5'd5, 32'h1234}) begin
            tests_failed++;
            $display("FAIL pass_wb5: got %h, expected %h",
                     {bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData}, {1'b1, 5'd5, 32'h1234});
        end
        tick();
        drive_wb(1'b1, 5'd0, 32'h4321);
        settle();
        tests_run++;
        if ({bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData} !== 38'd0) begin
            tests_failed++;
            $display("FAIL pass_r0_dropped: got %h, expected 0",
                     {bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData});
        end
        tick();
        drive_wb(1'b0, 5'd5, 32'h1234);
        settle();
        tests_run++;
        if (bus.RF_WriteEn !== 1'b0) begin
            tests_failed++;
            $display("FAIL pass_no_regwrite: got %b, expected 0", bus.RF_WriteEn);
        end
    endtask

    task automatic test_mdu_drain();
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        drive_mdu(1'b1, 5'd9, 32'hDEADBEEF);
        settle();
        tests_run++;
        if ({bus.MDU_Ready, bus.RF_WriteEn} !== 2'b10) begin
            tests_failed++;
            $display("FAIL drain_pre: ready/en got %b, expected 10", {bus.MDU_Ready, bus.RF_WriteEn});
        end
        tick();
        drive_mdu(1'b0, 5'd0, 32'd0);
        settle();
        tests_run++;
        if ({bus.Pend_Valid, bus.Pend_Rd, bus.MDU_Ready} !== {1'b1, 5'd9, 1'b0}) begin
            tests_failed++;
            $display("FAIL drain_pending: got %b, expected %b",
                     {bus.Pend_Valid, bus.Pend_Rd, bus.MDU_Ready}, {1'b1, 5'd9, 1'b0});
        end
        tests_run++;
        if ({bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData} !== {1'b1, 5'd9, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL drain_write: got %h, expected %h",
                     {bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData}, {1'b1, 5'd9, 32'hDEADBEEF});
        end
        tick();
        settle();
        tests_run++;
        if ({bus.Pend_Valid, bus.Pend_Rd, bus.MDU_Ready, bus.RF_WriteEn} !== {1'b0, 5'd0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL drain_post: got %b, expected %b",
                     {bus.Pend_Valid, bus.Pend_Rd, bus.MDU_Ready, bus.RF_WriteEn}, {1'b0, 5'd0, 1'b1, 1'b0});
        end
    endtask

    task automatic test_starvation();
        tick();
        drive_mdu(1'b1, 5'd3, 32'h33);
        tick();
        drive_mdu(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 6; i++) begin
            drive_wb(1'b1, 5'd7, 32'h70 + 32'(i));
            settle();
            tests_run++;
            if ({bus.Stall_Req, bus.RF_WriteAddr, bus.Pend_Rd} !== {(i >= 4), 5'd7, 5'd3}) begin
                tests_failed++;
                $display("FAIL starve_cycle%0d: stall/addr/pend got %b, expected %b", i,
                         {bus.Stall_Req, bus.RF_WriteAddr, bus.Pend_Rd}, {(i >= 4), 5'd7, 5'd3});
            end
            tick();
        end
        drive_wb(1'b0, 5'd0, 32'd0);
        settle();
        tests_run++;
        if ({bus.Stall_Req, bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData} !==
            {1'b1, 1'b1, 5'd3, 32'h33}) begin
            tests_failed++;
            $display("FAIL starve_drain: got %h, expected %h",
                     {bus.Stall_Req, bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData},
                     {1'b1, 1'b1, 5'd3, 32'h33});
        end
        tick();
        settle();
        tests_run++;
        if ({bus.Stall_Req, bus.Pend_Valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL starve_clear: stall/pend got %b, expected 00", {bus.Stall_Req, bus.Pend_Valid});
        end
    endtask

    task automatic test_waw();
        tick();
        drive_mdu(1'b1, 5'd4, 32'hAA);
        tick();
        drive_mdu(1'b0, 5'd0, 32'd0);
        drive_wb(1'b1, 5'd4, 32'hBB);
        settle();
        tests_run++;
        if ({bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData, bus.Pend_Valid} !==
            {1'b1, 5'd4, 32'hBB, 1'b1}) begin
            tests_failed++;
            $display("FAIL waw_wb_write: got %h, expected %h",
                     {bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData, bus.Pend_Valid},
                     {1'b1, 5'd4, 32'hBB, 1'b1});
        end
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            settle();
            tests_run++;
            if ({bus.RF_WriteEn, bus.Pend_Valid, bus.Stall_Req} !== 3'b000) begin
                tests_failed++;
                $display("FAIL waw_no_stale%0d: en/pend/stall got %b, expected 000", i,
                         {bus.RF_WriteEn, bus.Pend_Valid, bus.Stall_Req});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        drive_wb(1'b1, 5'd10, 32'h100);
        drive_mdu(1'b1, 5'd11, 32'h1111);
        settle();
        tests_run++;
        if (bus.MDU_Ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_first_ready: got %b, expected 1", bus.MDU_Ready);
        end
        tick();
        drive_mdu(1'b1, 5'd12, 32'h2222);
        for (int i = 0; i < 2; i++) begin
            drive_wb(1'b1, 5'd10, 32'h101 + 32'(i));
            settle();
            tests_run++;
            if ({bus.MDU_Ready, bus.Pend_Rd, bus.RF_WriteAddr} !== {1'b0, 5'd11, 5'd10}) begin
                tests_failed++;
                $display("FAIL b2b_blocked%0d: got %b, expected %b", i,
                         {bus.MDU_Ready, bus.Pend_Rd, bus.RF_WriteAddr}, {1'b0, 5'd11, 5'd10});
            end
            tick();
        end
        drive_wb(1'b0, 5'd0, 32'd0);
        settle();
        tests_run++;
        if ({bus.Stall_Req, bus.MDU_Ready, bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData} !==
            {1'b0, 1'b0, 1'b1, 5'd11, 32'h1111}) begin
            tests_failed++;
            $display("FAIL b2b_first_write: got %h, expected %h",
                     {bus.Stall_Req, bus.MDU_Ready, bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData},
                     {1'b0, 1'b0, 1'b1, 5'd11, 32'h1111});
        end
        tick();
        settle();
        tests_run++;
        if ({bus.MDU_Ready, bus.Pend_Valid, bus.RF_WriteEn} !== 3'b100) begin
            tests_failed++;
            $display("FAIL b2b_gap: ready/pend/en got %b, expected 100",
                     {bus.MDU_Ready, bus.Pend_Valid, bus.RF_WriteEn});
        end
        tick();
        drive_mdu(1'b0, 5'd0, 32'd0);
        settle();
        tests_run++;
        if ({bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData} !== {1'b1, 5'd12, 32'h2222}) begin
            tests_failed++;
            $display("FAIL b2b_second_write: got %h, expected %h",
                     {bus.RF_WriteEn, bus.RF_WriteAddr, bus.RF_WriteData}, {1'b1, 5'd12, 32'h2222});
        end
        tick();
        settle();
        tests_run++;
        if ({bus.RF_WriteEn, bus.Pend_Valid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL b2b_done: en/pend got %b, expected 00", {bus.RF_WriteEn, bus.Pend_Valid});
        end
    endtask

    task automatic test_reset_mid();
        tick();
        drive_mdu(1'b1, 5'd6, 32'h66);
        tick();
        drive_mdu(1'b0, 5'd0, 32'd0);
        drive_wb(1'b1, 5'd7, 32'h77);
        for (int i = 0; i < 4; i++) tick();
        settle();
        tests_run++;
        if ({bus.Stall_Req, bus.Pend_Valid, bus.Pend_Rd} !== {1'b1, 1'b1, 5'd6}) begin
            tests_failed++;
            $display("FAIL rmid_setup: got %b, expected %b",
                     {bus.Stall_Req, bus.Pend_Valid, bus.Pend_Rd}, {1'b1, 1'b1, 5'd6});
        end
        reset = 1'b1;
        #1;
        tests_run++;
        if ({bus.Stall_Req, bus.Pend_Valid, bus.Pend_Rd, bus.MDU_Ready, bus.RF_WriteEn,
             bus.RF_WriteAddr, bus.RF_WriteData} !== 45'd0) begin
            tests_failed++;
            $display("FAIL rmid_async: got %h, expected 0",
                     {bus.Stall_Req, bus.Pend_Valid, bus.Pend_Rd, bus.MDU_Ready, bus.RF_WriteEn,
                      bus.RF_WriteAddr, bus.RF_WriteData});
        end
        tick();
        drive_wb(1'b0, 5'd0, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            settle();
            tests_run++;
            if ({bus.RF_WriteEn, bus.Pend_Valid, bus.MDU_Ready} !== 3'b001) begin
                tests_failed++;
                $display("FAIL rmid_release%0d: en/pend/ready got %b, expected 001", i,
                         {bus.RF_WriteEn, bus.Pend_Valid, bus.MDU_Ready});
            end
            tick();
        end
    endtask

    initial begin
        drive_wb(1'b0, 5'd0, 32'd0);
        drive_mdu(1'b0, 5'd0, 32'd0);
        test_reset();
        test_passthrough();
        test_mdu_drain();
        test_starvation();
        test_waw();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Shares the single register-file write port between the pipeline write-back stage (MEM/WB outputs) and a multi-cycle multiply/divide unit (MDU). MDU results land in a one-entry holding buffer and drain into free write-back slots. A starvation counter raises a stall request so the pipeline injects a bubble when no free slot appears. Sits between the MEM/WB register, the MDU result interface, the register file write port and the hazard unit.

## Interface
- STARVE_LIMIT, 4: cycles a buffered result may wait (denied) before Stall_Req asserts; legal range 1..15
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high
- WB_Rd  in  5  destination register of instruction in WB
- WB_Result  in  32  write-back data (already MemtoReg-muxed)
- WB_RegWrite  in  1  WB instruction writes a register
- MDU_Valid  in  1  MDU result available
- MDU_Rd  in  5  MDU destination register
- MDU_Data  in  32  MDU result
- MDU_Ready  out  1  holding buffer can accept a result
- RF_WriteEn  out  1  register file write enable
- RF_WriteAddr  out  5  register file write address
- RF_WriteData  out  32  register file write data
- Stall_Req  out  1  request to hazard unit: insert bubble ahead of MEM/WB
- Pend_Valid  out  1  holding buffer occupied
- Pend_Rd  out  5  destination of buffered result (0 when empty)

## Operation
- State: buf_valid, buf_rd[4:0], buf_data[31:0], starve_cnt[3:0], Stall_Req (registered).
- wb_live = WB_RegWrite && (WB_Rd != 0). Writes to r0 are never issued.
- Grant, combinational, pipeline has fixed priority:
  - wb_live: RF_WriteEn=1, address/data = WB_Rd/WB_Result.
  - else buf_valid: RF_WriteEn=1, address/data = buf_rd/buf_data; buffer drains (grant_buf).
  - else RF_WriteEn=0, RF_WriteAddr=0, RF_WriteData=0.
- MDU_Ready = !buf_valid && !reset. Capture on MDU_Valid && MDU_Ready at the clock edge. A captured result with MDU_Rd==0 is dropped (buffer stays empty).
- No capture and drain in the same cycle, because Ready is low whenever the buffer is occupied.
- WAW supersede: if buf_valid && wb_live && WB_Rd==buf_rd, the buffered result is discarded at that edge without being written. The WB instruction is younger. starve_cnt and Stall_Req clear as on a drain.
- Starvation:
  - starve_cnt clears when the buffer is empty, drained or superseded.
  - Otherwise it increments when buf_valid && wb_live and saturates at STARVE_LIMIT.
  - Stall_Req is set at the edge where starve_cnt reaches STARVE_LIMIT. It holds until the edge that drains or supersedes the buffer, and clears there.
- Pend_Valid=buf_valid; Pend_Rd=buf_valid ? buf_rd : 0. The hazard unit uses these to stall readers of a pending MDU destination.

## Timing
- Reset (async assert): buf_valid=0, buf_rd=0, buf_data=0, starve_cnt=0, Stall_Req=0.
- Resulting output values during reset: MDU_Ready=0, Pend_Valid=0, Pend_Rd=0, RF_WriteEn=0, RF_WriteAddr=0, RF_WriteData=0. The write port is forced idle during reset.
- After reset deasserts, MDU_Ready=1 in the same cycle.
- Pipeline write: zero latency (combinational pass-through).
- MDU result: captured at edge N. Written to RF in cycle N+1 at the earliest, if that cycle has no wb_live. MDU_Ready returns high in the cycle after the drain edge.
- Stall_Req rises exactly STARVE_LIMIT consecutive denied cycles after capture.
- Reset mid-operation discards the buffered result; no RF write occurs for it.

## Test plan
- Idle pass-through: WB_RegWrite=1, WB_Rd=5, WB_Result=0x1234 with no MDU activity -> same cycle RF_WriteEn=1, addr 5, data 0x1234; WB_Rd=0 -> RF_WriteEn=0.
- MDU drain: MDU_Valid=1, Rd=9, Data=0xDEADBEEF with WB idle -> next cycle RF_WriteEn=1, addr 9, data 0xDEADBEEF, Pend_Valid=1 then 0; MDU_Ready low for exactly one cycle.
- Starvation: capture Rd=3, then wb_live to Rd=7 for 6 cycles with STARVE_LIMIT=4 -> Stall_Req rises 4 cycles after capture. On the first wb-idle cycle, RF writes r3 and Stall_Req clears at that edge.
- WAW supersede: buffer Rd=4 data 0xAA, then WB writes Rd=4 data 0xBB -> RF writes 0xBB only; buffer empties and r4 is never written with 0xAA.
- Back-pressure: MDU_Valid held high with two results while WB is busy -> second result is not accepted (MDU_Ready=0) until the first drains; both are eventually written in order.
- Reset mid-operation: assert reset with the buffer full and Stall_Req=1 -> all outputs go to reset values asynchronously, and no write of the buffered value occurs after release.
